// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry, line/tag types and FSM encoding for the 2-way icache
package icache_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int TAG_W    = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int LINE_W   = 256;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    FILL
  } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one way of the icache: per-set valid bit, tag and 256-bit line in flops
//
// Ports:
//   clk, reset_n        clock; synchronous active-high reset clears every valid bit
//   rd_index            set to look up (combinational read)
//   rd_valid/tag/data   contents of the addressed set
//   wr_en, wr_index     fill strobe and target set
//   wr_tag, wr_data     tag and line written on fill; valid is set alongside
module icache_way
  import icache_pkg::*;
#(
  parameter int IDX_W = icache_pkg::S_INDEX,
  parameter int TW    = 32 - icache_pkg::S_OFFSET - IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [TW-1:0]    rd_tag,
  output line_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TW-1:0]    wr_tag,
  input  line_t            wr_data
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  line_t           data_q [SETS];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_2way.sv
// rtl/icache_2way.sv - read-only 2-way set-associative L1 icache with LRU replacement
//
// Ports:
//   clk, reset_n          clock; synchronous active-high reset (asserted = 1)
//   mem_read/mem_address  CPU fetch request, held until mem_resp
//   mem_rdata, mem_resp   fetched word and one-cycle completion
//   pmem_read/address     line request to the arbiter instruction port
//   pmem_byte_en          always 4'b1111
//   pmem_rdata/pmem_resp  returned line and its one-cycle strobe
module icache_2way
  import icache_pkg::*;
#(
  parameter int S_INDEX = icache_pkg::S_INDEX
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  output logic [3:0]   pmem_byte_en,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TW     = 32 - S_OFFSET - S_INDEX;
  localparam int LADDR_W = 32 - S_OFFSET;

  icache_state_t state_q, state_d;

  logic [S_INDEX-1:0] addr_index;
  logic [TW-1:0]      addr_tag;
  logic [2:0]         word_sel;
  logic               unused_byte_bits;

  logic [LADDR_W-1:0] miss_line_q;
  logic [S_INDEX-1:0] miss_index;
  logic [TW-1:0]      miss_tag;

  logic [S_INDEX-1:0] rd_index;
  logic               v0, v1;
  logic [TW-1:0]      t0, t1;
  line_t              d0, d1;

  logic [(1<<S_INDEX)-1:0] lru_q;

  logic  hit0, hit1, lookup_hit, hit_way, victim;
  logic  hit, fill_en, in_miss;
  line_t hit_line;

  assign addr_index       = mem_address[S_OFFSET +: S_INDEX];
  assign addr_tag         = mem_address[31 -: TW];
  assign word_sel         = mem_address[4:2];
  assign unused_byte_bits = ^mem_address[1:0];

  assign miss_index = miss_line_q[S_INDEX-1:0];
  assign miss_tag   = miss_line_q[LADDR_W-1 -: TW];

  // One read port per way: the fetch set while idle, the latched miss set
  // otherwise so victim selection sees the set being filled.
  assign rd_index = (state_q == IDLE) ? addr_index : miss_index;

  icache_way #(.IDX_W(S_INDEX), .TW(TW)) u_way0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_index (rd_index),
    .rd_valid (v0),
    .rd_tag   (t0),
    .rd_data  (d0),
    .wr_en    (fill_en && !victim),
    .wr_index (miss_index),
    .wr_tag   (miss_tag),
    .wr_data  (pmem_rdata)
  );

  icache_way #(.IDX_W(S_INDEX), .TW(TW)) u_way1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_index (rd_index),
    .rd_valid (v1),
    .rd_tag   (t1),
    .rd_data  (d1),
    .wr_en    (fill_en && victim),
    .wr_index (miss_index),
    .wr_tag   (miss_tag),
    .wr_data  (pmem_rdata)
  );

  assign hit0       = v0 && (t0 == addr_tag);
  assign hit1       = v1 && (t1 == addr_tag);
  assign lookup_hit = hit0 || hit1;
  // Way 0 wins if both ever match.
  assign hit_way    = !hit0;

  // Fill an empty way first; only when both are valid consult LRU.
  assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[miss_index]);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    fill_en = 1'b0;
    in_miss = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          if (lookup_hit) begin
            hit = 1'b1;
          end else begin
            state_d = MISS;
          end
        end
      end
      MISS: begin
        in_miss = 1'b1;
        if (pmem_resp) begin
          fill_en = !reset_n;
          state_d = FILL;
        end
      end
      // Dropping the request here is what stops the arbiter re-issuing.
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      miss_line_q <= '0;
    end else if (state_q == IDLE && mem_read && !lookup_hit) begin
      miss_line_q <= mem_address[31:S_OFFSET];
    end
  end

  // lru bit names the way to replace next, i.e. the one not just touched.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      lru_q <= '0;
    end else if (hit) begin
      lru_q[addr_index] <= ~hit_way;
    end else if (fill_en) begin
      lru_q[miss_index] <= ~victim;
    end
  end

  assign hit_line     = hit_way ? d1 : d0;
  assign mem_resp     = hit && !reset_n;
  assign mem_rdata    = mem_resp ? hit_line[{word_sel, 5'b0} +: 32] : 32'h0;
  assign pmem_read    = in_miss && !reset_n;
  assign pmem_address = pmem_read ? {miss_line_q, 5'b0} : 32'h0;
  assign pmem_byte_en = 4'b1111;

endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Read-only, 2-way set-associative L1 instruction cache with LRU replacement, directly upstream of the I/D-to-L2 memory arbiter.
- Serves 32-bit instruction fetches from the CPU fetch stage.
- On a miss, requests a full 256-bit line on the arbiter's instruction port.
- Captures the line on the single response cycle, then replays the fetch as a hit.

Parameters:
- S_INDEX, 3, set-index bits (8 sets); tag width = 32 - 5 - S_INDEX.
- S_OFFSET, 5, byte-offset bits (32-byte line); fixed, not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-high reset (asserted = 1, sampled on posedge clk; suffix is the codebase's name, not its polarity).
- mem_read  in  1  CPU fetch request; held high until mem_resp.
- mem_address  in  32  CPU fetch byte address; held stable until mem_resp.
- mem_rdata  out  32  fetched word; valid only when mem_resp = 1.
- mem_resp  out  1  one-cycle fetch completion.
- pmem_read  out  1  line request to arbiter instruction port.
- pmem_address  out  32  line-aligned request address ({tag, index, 5'b0}).
- pmem_byte_en  out  4  constant 4'b1111.
- pmem_rdata  in  256  returned line; valid only in the pmem_resp cycle.
- pmem_resp  in  1  one-cycle line-ready strobe from arbiter.

Behaviour:
- Address split: offset = addr[4:0], index = addr[S_OFFSET+S_INDEX-1:S_OFFSET], tag = remaining upper bits. Word select = offset[4:2]; mem_rdata = line[32*offset[4:2] +: 32]. offset[1:0] is ignored.
- Storage per set: valid[2], tag[2], data[2] (256 b each), lru (1 b = way to replace next). All held in flops.
- Reset (any state, including mid-miss):
  - all valid = 0, all lru = 0, state = IDLE.
  - mem_resp = 0, pmem_read = 0, mem_rdata = 0, pmem_address = 0.
  - Tag/data contents are don't-care.
- FSM states: IDLE, MISS, FILL.
- IDLE:
  - hit = mem_read && (valid[w] && tag[w] == tag) for some way w.
  - On hit: mem_resp = 1 combinationally in the same cycle, mem_rdata from way w, lru[index] <= ~w. Stay in IDLE. Single-cycle hit latency; back-to-back hits allowed every cycle.
  - On mem_read && !hit: latch the line address; next state = MISS.
  - No mem_read: hold all state.
- MISS:
  - pmem_read = 1 and pmem_address = latched line address, held every cycle until pmem_resp.
  - On pmem_resp:
    - Victim = way 0 if invalid, else way 1 if invalid, else lru[index].
    - Write pmem_rdata, tag and valid = 1 into the victim; lru[index] <= ~victim.
    - Next state = FILL.
- FILL:
  - pmem_read = 0. This is mandatory: the arbiter re-issues if the request is still held after its response cycle.
  - Next state = IDLE, where the still-held fetch hits.
  - Miss latency = arbiter latency + 2 cycles.
- pmem_resp outside MISS is ignored; no state change.
- mem_read dropped during MISS: the fill still completes, no mem_resp, return to IDLE.
- Both ways matching (illegal by construction): way 0 takes priority.
- mem_resp is never asserted in MISS or FILL.
- pmem_byte_en is always 4'b1111, including during reset.

Decomposition:
- Shared package icache_pkg:
  - S_OFFSET, S_INDEX, TAG_W, NUM_SETS, LINE_W = 256.
  - Typedef line_t (logic [255:0]), tag_t.
  - Enum icache_state_t {IDLE, MISS, FILL}.
- One sub-module, icache_way:
  - One way's valid/tag/data arrays.
  - Synchronous write with reset-clear of valid; combinational read by index.
  - Instantiated twice.
- The top holds the FSM, LRU bits, hit/victim logic and word mux.

Test Plan:
- Cold miss: reset, then mem_read at 0x0000_0044.
  - Required: pmem_read with pmem_address 0x0000_0040 until pmem_resp.
  - Return a line whose word k = 0xA000_0000+k.
  - Required: pmem_read low the next cycle; mem_resp 2 cycles after pmem_resp with mem_rdata 0xA000_0001.
- Hit latency: after the fill above, fetch 0x0000_005C.
  - Required: mem_resp in the same cycle, mem_rdata 0xA000_0007, no pmem_read.
- Two-way fill and LRU eviction: fill 0x0000_0000 (way 0), then 0x0000_0100 (same set, way 1), then hit 0x0000_0000, then miss 0x0000_0200.
  - Required: way 1 (0x100) is evicted.
  - Required: refetching 0x0000_0000 hits; 0x0000_0100 misses.
- Ignore stray response: pulse pmem_resp while in IDLE with mem_read = 0.
  - Required: no array change; a subsequent fetch of the same address misses.
- Reset mid-miss: assert reset_n while pmem_read = 1.
  - Required: next cycle pmem_read = 0, mem_resp = 0; a previously cached address now misses.
- Request dropped during miss: deassert mem_read while in MISS, then deliver pmem_resp.
  - Required: no mem_resp; later fetch of that line hits in 1 cycle.
